// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo_ring write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int BURST_CNT_W = 8;
    localparam int STATS_CNT_W = 16;
    // Widest channel tag any legal configuration (up to 16 requesters) needs.
    localparam int MAX_TAG_W   = 4;

    // Channel tag attached to each written word. The caller zero-extends the
    // granted index into the argument; the result is trimmed back to TAG_WIDTH.
    function automatic logic [MAX_TAG_W-1:0] tag_of(input logic [MAX_TAG_W-1:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotate-priority picker: finds the first set request at or above the pointer,
// wrapping from N_REQ-1 back to 0.
module fifo_arb_rr_pick #(
    parameter int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    // Walk the offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        found = 1'b0;
        idx   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % N_REQ]) begin
                found = 1'b1;
                idx   = PTR_W'((int'(ptr) + off) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_ring_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_ring write port between N_REQ producers.
// Grants are locked to one requester for up to MAX_BURST words, and every
// accepted word leaves through a one-cycle register stage tagged {channel, payload}.
// Define FIFO_ARB_STATS_EN to add per-channel accepted-word counters
// (o_word_count) and their synchronous clear input (i_stats_clr).
module fifo_ring_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 28,
    parameter int MAX_BURST  = 8,
    localparam int TAG_WIDTH = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              i_req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_data,
    output logic [N_REQ-1:0]              o_req_ready,
    output logic                          o_wr_valid,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] o_wr_data,
    input  logic                          i_fifo_ready,
    input  logic                          i_fifo_full_next,
    output logic [TAG_WIDTH-1:0]          o_grant_idx,
    output logic                          o_busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                          i_stats_clr,
    output logic [N_REQ*STATS_CNT_W-1:0]  o_word_count
`endif
);

    arb_state_t            state;
    logic [TAG_WIDTH-1:0]  rr_ptr;
    logic [TAG_WIDTH-1:0]  grant_idx;
    logic [BURST_CNT_W-1:0] burst_cnt;

    logic                  pick_found;
    logic [TAG_WIDTH-1:0]  pick_idx;
    logic                  accept_ok;
    logic                  accept;
    logic [TAG_WIDTH-1:0]  acc_idx;

    function automatic logic [TAG_WIDTH-1:0] wrap_inc(input logic [TAG_WIDTH-1:0] i);
        return (i == TAG_WIDTH'(N_REQ - 1)) ? '0 : i + TAG_WIDTH'(1);
    endfunction

    fifo_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (i_req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant decode: locked requester in BURST, rotate-priority pick in IDLE.
    // accept_ok also blocks when the word already in the write stage will fill
    // the FIFO, so the register stage can never push a word into a full ring.
    always_comb begin
        accept_ok   = i_fifo_ready && !(o_wr_valid && i_fifo_full_next);
        o_req_ready = '0;
        acc_idx     = pick_idx;
        if (state == BURST) begin
            acc_idx = grant_idx;
            if (i_req_valid[grant_idx] && accept_ok) o_req_ready[grant_idx] = 1'b1;
        end else if (pick_found && accept_ok) begin
            o_req_ready[pick_idx] = 1'b1;
        end
        // Nothing may be offered while reset is held.
        if (!rst_n) o_req_ready = '0;
    end

    assign accept = |o_req_ready;

    // Arbitration state: burst lock, burst length and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            burst_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_idx <= pick_idx;
                        burst_cnt <= BURST_CNT_W'(1);
                        if (MAX_BURST > 1) state  <= BURST;
                        else               rr_ptr <= wrap_inc(pick_idx);
                    end
                end
                BURST: begin
                    if (!i_req_valid[grant_idx]) begin
                        state  <= IDLE;
                        rr_ptr <= wrap_inc(grant_idx);
                    end else if (accept) begin
                        burst_cnt <= burst_cnt + BURST_CNT_W'(1);
                        if (burst_cnt + BURST_CNT_W'(1) == BURST_CNT_W'(MAX_BURST)) begin
                            state  <= IDLE;
                            rr_ptr <= wrap_inc(grant_idx);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-cycle write stage toward the FIFO; reset discards a word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_wr_valid <= 1'b0;
            o_wr_data  <= '0;
        end else begin
            o_wr_valid <= accept;
            if (accept) begin
                o_wr_data <= {TAG_WIDTH'(tag_of(MAX_TAG_W'(acc_idx))),
                              i_req_data[int'(acc_idx)*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    assign o_grant_idx = grant_idx;
    assign o_busy      = (state == BURST);

`ifdef FIFO_ARB_STATS_EN
    logic [STATS_CNT_W-1:0] word_cnt [N_REQ];

    // Per-channel accepted-word counters; the synchronous clear beats a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: a small counter array is cleared in reset; a large RAM would not be.
            for (int i = 0; i < N_REQ; i++) word_cnt[i] <= '0;
        end else if (i_stats_clr) begin
            for (int i = 0; i < N_REQ; i++) word_cnt[i] <= '0;
        end else if (accept && word_cnt[acc_idx] != '1) begin
            word_cnt[acc_idx] <= word_cnt[acc_idx] + STATS_CNT_W'(1);
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stats_out
        assign o_word_count[g*STATS_CNT_W +: STATS_CNT_W] = word_cnt[g];
    end
`endif

endmodule

// File: tb/tb_fifo_ring_wr_arbiter.sv
// Self-checking bench for fifo_ring_wr_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural model of the arbitration rules
// and a 256-entry FIFO occupancy model driving the back-pressure inputs.
module tb_fifo_ring_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 28;
    localparam int MB  = 8;
    localparam int TW  = 2;
    localparam int DEPTH = 256;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N*DW-1:0]    req_data;
    logic [N-1:0]       req_ready;
    logic               wr_valid;
    logic [TW+DW-1:0]   wr_data;
    logic               fifo_ready;
    logic               fifo_full_next;
    logic [TW-1:0]      grant_idx;
    logic               busy;
`ifdef FIFO_ARB_STATS_EN
    logic               stats_clr;
    logic [N*16-1:0]    word_count;
    int                 m_wc [N];
`endif

    fifo_ring_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req_valid      (req_valid),
        .i_req_data       (req_data),
        .o_req_ready      (req_ready),
        .o_wr_valid       (wr_valid),
        .o_wr_data        (wr_data),
        .i_fifo_ready     (fifo_ready),
        .i_fifo_full_next (fifo_full_next),
        .o_grant_idx      (grant_idx),
        .o_busy           (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .i_stats_clr      (stats_clr),
        .o_word_count     (word_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Producers: each channel offers the head of its queue.
    logic [DW-1:0] pq [N][$];
    bit            hold [N];
    int            hold_pct = 0;

    // FIFO occupancy model.
    int fill = 0;
    int pop_pct = 100;
    int n_writes = 0;
    int overflow = 0;

    // Arbitration model: owner = locked requester, -1 when none.
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_cnt   = 0;
    int            m_grant = 0;
    bit            m_wr_valid = 1'b0;
    logic [TW+DW-1:0] m_wr_data = '0;

    int acc_log [$];
    int wait_cnt [N];
    int max_wait [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit all_empty();
        for (int ch = 0; ch < N; ch++) if (pq[ch].size() != 0) return 1'b0;
        return (fill == 0) && !m_wr_valid;
    endfunction

    task automatic drive_inputs();
        for (int ch = 0; ch < N; ch++) begin
            hold[ch] = ($urandom_range(99) < hold_pct);
            req_valid[ch] = (pq[ch].size() != 0) && !hold[ch];
            req_data[ch*DW +: DW] = (pq[ch].size() != 0) ? pq[ch][0] : DW'($urandom());
        end
        fifo_ready     = (fill < DEPTH);
        fifo_full_next = (fill == DEPTH - 1);
    endtask

    // One clock: drive, check at the falling edge, advance the models across the rising edge.
    task automatic cycle();
        bit            ok;
        int            idx;
        logic [N-1:0]  exp_ready;
        bit            pop;
        int            nfill;
        bit            nv;
        logic [TW+DW-1:0] nd;
        logic [DW-1:0] w;
        logic [TW-1:0] tg;

        drive_inputs();
        @(negedge clk);
        ok  = fifo_ready && !(m_wr_valid && fifo_full_next);
        idx = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (idx < 0 && req_valid[(m_ptr + k) % N]) idx = (m_ptr + k) % N;
            if (!ok) idx = -1;
        end else if (req_valid[m_owner] && ok) begin
            idx = m_owner;
        end
        exp_ready = '0;
        if (idx >= 0) exp_ready[idx] = 1'b1;

        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("wr_valid", 64'(wr_valid), 64'(m_wr_valid));
        if (m_wr_valid) check("wr_data", 64'(wr_data), 64'(m_wr_data));
        check("busy", 64'(busy), 64'(m_owner >= 0));
        check("grant_idx", 64'(grant_idx), 64'(m_grant));
`ifdef FIFO_ARB_STATS_EN
        for (int ch = 0; ch < N; ch++)
            check($sformatf("word_count%0d", ch), 64'(word_count[ch*16 +: 16]), 64'(m_wc[ch]));
`endif

        // FIFO side: the word in the write stage lands this edge.
        pop   = (fill > 0) && ($urandom_range(99) < pop_pct);
        nfill = fill - int'(pop) + int'(m_wr_valid);
        if (m_wr_valid) begin
            n_writes++;
            if (nfill > DEPTH) begin
                overflow++;
                nfill = DEPTH;
            end
        end

        // Fairness: words granted to others while a channel keeps waiting.
        for (int ch = 0; ch < N; ch++) begin
            if (!req_valid[ch] || ch == idx) wait_cnt[ch] = 0;
            else if (idx >= 0) wait_cnt[ch]++;
            if (wait_cnt[ch] > max_wait[ch]) max_wait[ch] = wait_cnt[ch];
        end

        nv = (idx >= 0);
        nd = m_wr_data;
        if (idx >= 0) begin
            w  = pq[idx].pop_front();
            tg = TW'(idx);
            nd = {tg, w};
            acc_log.push_back(idx);
`ifdef FIFO_ARB_STATS_EN
            if (!stats_clr && m_wc[idx] < 16'hFFFF) m_wc[idx]++;
`endif
        end
`ifdef FIFO_ARB_STATS_EN
        if (stats_clr) for (int ch = 0; ch < N; ch++) m_wc[ch] = 0;
`endif

        if (m_owner < 0) begin
            if (idx >= 0) begin
                m_grant = idx;
                m_cnt   = 1;
                if (MB > 1) m_owner = idx;
                else        m_ptr = (idx + 1) % N;
            end
        end else if (!req_valid[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (idx >= 0) begin
            m_cnt++;
            if (m_cnt == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end

        @(posedge clk);
        #1;
        m_wr_valid = nv;
        m_wr_data  = nd;
        fill       = nfill;
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear at once.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        req_valid  = '1;
        fifo_ready = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_wr_valid", 64'(wr_valid), 64'(0));
        check("rst_wr_data", 64'(wr_data), 64'(0));
        check("rst_grant_idx", 64'(grant_idx), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
`ifdef FIFO_ARB_STATS_EN
        check("rst_word_count", 64'(word_count), 64'(0));
        for (int ch = 0; ch < N; ch++) m_wc[ch] = 0;
`endif
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_grant = 0;
        m_wr_valid = 1'b0; m_wr_data = '0;
        for (int ch = 0; ch < N; ch++) begin
            pq[ch].delete();
            wait_cnt[ch] = 0;
        end
        acc_log.delete();
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int ch, input int cnt);
        for (int i = 0; i < cnt; i++) pq[ch].push_back(DW'($urandom()));
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (!all_empty() && c < 3000) begin
            cycle();
            c++;
        end
        check(tag, 64'(all_empty()), 64'(1));
    endtask

    initial begin
        int c;
        int bad;
        rst_n = 1'b1;
        req_valid = '0;
        req_data = '0;
        fifo_ready = 1'b1;
        fifo_full_next = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        for (int ch = 0; ch < N; ch++) begin
            hold[ch] = 1'b0;
            wait_cnt[ch] = 0;
            max_wait[ch] = 0;
        end
        apply_reset();

        // Single requester: five words on channel 2 into an empty FIFO.
        push_words(2, 5);
        drain("ch2_drain");
        bad = 0;
        foreach (acc_log[i]) if (acc_log[i] != 2) bad++;
        check("ch2_words", 64'(acc_log.size()), 64'(5));
        check("ch2_tags", 64'(bad), 64'(0));

        // Channel 1 drops valid after three words; the next grant is channel 2.
        apply_reset();
        push_words(1, 3);
        push_words(2, 4);
        c = 0;
        while (pq[1].size() != 0 && c < 50) begin cycle(); c++; end
        check("ch1_first3", 64'(acc_log.size()), 64'(3));
        cycle();
        push_words(1, 3);
        c = 0;
        while (acc_log.size() < 4 && c < 50) begin cycle(); c++; end
        check("after_drop_grant", 64'(acc_log.size() >= 4 ? acc_log[3] : -1), 64'(2));
        drain("drop_drain");

        // All four saturate a non-draining FIFO: bursts of 8 in order, exactly 256 writes.
        apply_reset();
        pop_pct = 0;
        n_writes = 0;
        for (int ch = 0; ch < N; ch++) push_words(ch, 65);
        for (int i = 0; i < 300; i++) cycle();
        check("full_accepts", 64'(acc_log.size()), 64'(DEPTH));
        check("full_writes", 64'(n_writes), 64'(DEPTH));
        check("full_fill", 64'(fill), 64'(DEPTH));
        bad = 0;
        foreach (acc_log[i]) if (acc_log[i] != (i / MB) % N) bad++;
        check("burst_order", 64'(bad), 64'(0));
        pop_pct = 100;
        drain("full_drain");

        // Reset while channel 3 is mid-burst; afterwards the search restarts at channel 0.
        apply_reset();
        push_words(3, 6);
        c = 0;
        while (busy !== 1'b1 && c < 20) begin cycle(); c++; end
        check("ch3_busy", 64'(busy), 64'(1));
        cycle();
        apply_reset();
        push_words(3, 2);
        push_words(0, 2);
        c = 0;
        while (acc_log.size() == 0 && c < 20) begin cycle(); c++; end
        check("post_reset_first", 64'(acc_log.size() > 0 ? acc_log[0] : -1), 64'(0));
        drain("post_reset_drain");

`ifdef FIFO_ARB_STATS_EN
        // Statistics: 10 words on ch0, 7 on ch3, then a clear colliding with a ch0 accept.
        apply_reset();
        push_words(0, 10);
        drain("stats_ch0");
        push_words(3, 7);
        drain("stats_ch3");
        cycle();
        check("stats_c0", 64'(word_count[0 +: 16]), 64'(10));
        check("stats_c1", 64'(word_count[16 +: 16]), 64'(0));
        check("stats_c3", 64'(word_count[48 +: 16]), 64'(7));
        push_words(0, 1);
        c = acc_log.size();
        stats_clr = 1'b1;
        cycle();
        stats_clr = 1'b0;
        check("stats_clr_accept", 64'(acc_log.size() - c), 64'(1));
        check("stats_cleared", 64'(word_count), 64'(0));
        drain("stats_drain");
`endif

        // Random traffic with random back-pressure and valid gaps.
        apply_reset();
        for (int ch = 0; ch < N; ch++) max_wait[ch] = 0;
        hold_pct = 15;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) pop_pct = $urandom_range(90, 20);
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(99) < 30 && pq[ch].size() < 40) push_words(ch, $urandom_range(4, 1));
            cycle();
        end
        hold_pct = 0;
        pop_pct = 100;
        drain("random_drain");
        for (int ch = 0; ch < N; ch++)
            check($sformatf("fair_ch%0d", ch), 64'(max_wait[ch] <= (N - 1) * MB), 64'(1));
        check("no_overflow", 64'(overflow), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_ring_wr_arbiter.md
Name: fifo_ring_wr_arbiter

Overview:
- Shares one fifo_ring write port between N_REQ independent producers.
- Round-robin grant with a bounded burst lock per requester.
- Registered write stage drives the FIFO's i_wr_valid/i_wr_data, each word tagged with its source channel index.
- Sits directly in front of fifo_ring; a single consumer drains the FIFO and demultiplexes words by tag.

Parameters:
- N_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 28: payload width per requester.
- TAG_WIDTH, $clog2(N_REQ): channel tag width, derived, not overridable.
- MAX_BURST, 8: max consecutive words granted to one requester before forced rotation, 1..255.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  N_REQ  per-requester word valid.
- i_req_data  in  N_REQ x DATA_WIDTH  per-requester payload, packed, channel n at [n*DATA_WIDTH +: DATA_WIDTH].
- o_req_ready  out  N_REQ  per-requester accept, one-hot or zero.
- o_wr_valid  out  1  to fifo_ring i_wr_valid.
- o_wr_data  out  TAG_WIDTH+DATA_WIDTH  to fifo_ring i_wr_data, {tag, payload}.
- i_fifo_ready  in  1  fifo_ring o_ready.
- i_fifo_full_next  in  1  fifo_ring o_full_next.
- o_grant_idx  out  TAG_WIDTH  index of the current or last granted channel.
- o_busy  out  1  high while in state BURST.

Behaviour:
- Reset (async assert, sync release), all outputs 0:
  - o_req_ready=0, o_wr_valid=0, o_wr_data=0, o_grant_idx=0, o_busy=0.
  - RR pointer=0, burst counter=0, state=IDLE.
- Handshake: a word transfers on a rising clk when i_req_valid[n] && o_req_ready[n].
- Transferred words appear on o_wr_valid/o_wr_data exactly 1 cycle later, held for 1 cycle only.
- o_wr_valid never asserts except for an accepted word.
- Back-pressure: accept_ok = i_fifo_ready && !(o_wr_valid && i_fifo_full_next). While accept_ok=0, o_req_ready=0.
  - Overflow is impossible even with the 1-cycle write stage in flight.
- o_req_ready is combinational from state, RR pointer, i_req_valid and accept_ok. At most one bit is high.
- State IDLE:
  - Search from RR pointer upward, wrapping N_REQ-1 -> 0, for the first valid requester.
  - If found and accept_ok: grant it, set o_grant_idx, burst counter=1. Go BURST if MAX_BURST>1, else stay IDLE with pointer=idx+1.
- State BURST: grant stays locked to o_grant_idx.
  - Each accepted word increments the counter.
  - Exit to IDLE with pointer=o_grant_idx+1 (mod N_REQ) when the counter reaches MAX_BURST on an accept, or the locked requester drops i_req_valid.
  - A cycle with accept_ok=0 does not exit BURST or change the counter.
- Fairness: no requester waits more than (N_REQ-1)*MAX_BURST accepted words while valid.
- Simultaneous requests: pure RR order from the pointer. Index 0 has no fixed priority.
- Reset mid-burst: state, counter and pointer clear immediately. A pending registered word is discarded (o_wr_valid=0).
- Widths: counter is 8 bits. Tag = granted index zero-extended to TAG_WIDTH.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- When defined, adds output o_word_count (N_REQ x 16):
  - per-channel count of accepted words, saturating at 16'hFFFF;
  - cleared by rst_n;
  - plus input i_stats_clr (1), a synchronous clear of all counters. If a clear and an accept occur in the same cycle, the clear wins.
- When not defined, neither port exists and no counter logic is generated.

Decomposition:
- Package fifo_arb_pkg holds: the state enum typedef (IDLE, BURST), BURST_CNT_W=8, STATS_CNT_W=16, and function tag_of(idx).
- Sub-module fifo_arb_rr_pick: combinational rotate-priority picker.
  - Inputs: req vector, pointer.
  - Outputs: found, idx.
  - Instantiated once.

Test Plan:
- Single requester, ch2 valid with 5 words, FIFO empty -> o_wr_data tags all 2, payload order preserved, o_wr_valid exactly 1 cycle after each accept, o_busy high for 5 accepts.
- All 4 valid continuously, MAX_BURST=8 -> grants in bursts of 8 in order 0,1,2,3,0..., 256 words written, o_fill_count=256, o_full=1.
- FIFO at 255 words with one word in the write stage -> o_req_ready all 0 that cycle, no 257th write, o_full=1 with no overwrite.
- ch1 drops valid after 3 words mid-burst -> state returns to IDLE, next grant goes to ch2, not ch1.
- rst_n pulsed low during burst on ch3 -> all outputs 0 asynchronously; after release the first grant starts from ch0.
- With FIFO_ARB_STATS_EN: 10 words ch0, 7 words ch3, then i_stats_clr together with a ch0 accept -> counts 10/0/0/7 before the clear, all 0 after.
